// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: instruction encodings and feeder FSM states shared with the CPU core
package cpu_defs_pkg;
  localparam int INSTR_W = 16;
  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_HALT = 5'b00001;
  localparam logic [INSTR_W-1:0] NOP_WORD  = {OP_NOP, 11'b0};
  localparam logic [INSTR_W-1:0] HALT_WORD = {OP_HALT, 11'b0};
  typedef enum logic [1:0] {S_IDLE, S_START, S_FEED, S_DONE} feed_state_t;
  function automatic logic is_halt(input logic [INSTR_W-1:0] w);
    return w[INSTR_W-1 -: 5] == OP_HALT;
  endfunction
endpackage

// File: rtl/prog_buf.sv
// prog_buf: DEPTH x 16 register-file RAM, synchronous write, asynchronous read
module prog_buf
  import cpu_defs_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic clock,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/cpu_prog_feeder.sv
// cpu_prog_feeder: replays a preloaded program onto the CPU instruction inputs,
// one word per unpaused cycle, stopping on and holding the first HALT word.
module cpu_prog_feeder
  import cpu_defs_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [AW:0] prog_len,
  input  logic run,
  input  logic pause,
  output logic cpu_enable,
  output logic cpu_start,
  output logic [INSTR_W-1:0] i_datain,
  output logic busy,
  output logic done
);
  feed_state_t state, state_n;
  logic [AW:0] len_q, len_n, idx, idx_n, len_sat;
  logic [INSTR_W-1:0] rd_word, word, data_n;
  logic en_n, start_n, busy_n, done_n, idle_like, in_range;
  assign idle_like = state == S_IDLE || state == S_DONE;
  assign in_range = idx < len_q;
  assign len_sat = prog_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : prog_len;
  assign word = in_range ? rd_word : HALT_WORD;
  prog_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clock(clock),
    .we(load_we && idle_like),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(idx[AW-1:0]),
    .rdata(rd_word)
  );
  // Outputs are registered from the current state, so they trail the state by one edge.
  always_comb begin
    state_n = state;
    len_n = len_q;
    idx_n = idx;
    data_n = i_datain;
    en_n = 1'b0;
    start_n = 1'b0;
    busy_n = 1'b0;
    done_n = 1'b0;
    case (state)
      S_IDLE: data_n = NOP_WORD;
      S_START: begin
        en_n = 1'b1;
        start_n = 1'b1;
        busy_n = 1'b1;
        data_n = NOP_WORD;
        state_n = S_FEED;
      end
      S_FEED: begin
        busy_n = 1'b1;
        if (!pause) begin
          en_n = 1'b1;
          data_n = word;
          idx_n = in_range ? idx + (AW+1)'(1) : idx;
          state_n = (!in_range || is_halt(word)) ? S_DONE : S_FEED;
        end
      end
      default: begin
        en_n = 1'b1;
        done_n = 1'b1;
      end
    endcase
    if (run && idle_like) begin
      state_n = S_START;
      len_n = len_sat;
      idx_n = '0;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      len_q <= '0;
      idx <= '0;
      cpu_enable <= 1'b0;
      cpu_start <= 1'b0;
      i_datain <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      len_q <= len_n;
      idx <= idx_n;
      cpu_enable <= en_n;
      cpu_start <= start_n;
      i_datain <= data_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_cpu_prog_feeder.sv
// tb_cpu_prog_feeder: directed vectors for the program feeder with hand-computed words
module tb_cpu_prog_feeder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic load_we = 1'b0;
  logic run = 1'b0;
  logic pause = 1'b0;
  logic [3:0] load_addr = '0;
  logic [15:0] load_data = '0;
  logic [4:0] prog_len = '0;
  logic cpu_enable, cpu_start, busy, done;
  logic [15:0] i_datain;
  int checks = 0;
  int failures = 0;
  always #5 clock = ~clock;
  cpu_prog_feeder #(.DEPTH(16), .AW(4)) dut (
    .clock(clock),
    .reset(reset),
    .load_we(load_we),
    .load_addr(load_addr),
    .load_data(load_data),
    .prog_len(prog_len),
    .run(run),
    .pause(pause),
    .cpu_enable(cpu_enable),
    .cpu_start(cpu_start),
    .i_datain(i_datain),
    .busy(busy),
    .done(done)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clock);
  endtask
  task automatic load(input logic [3:0] a, input logic [15:0] d);
    load_we = 1'b1;
    load_addr = a;
    load_data = d;
    tick;
    load_we = 1'b0;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_en"}, cpu_enable, 0);
    check({tag, "_start"}, cpu_start, 0);
    check({tag, "_data"}, i_datain, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask
  task automatic start_run(input logic [4:0] n);
    prog_len = n;
    run = 1'b1;
    tick;
    run = 1'b0;
    check("pre_start", cpu_start, 0);
    tick;
    check("start", cpu_start, 1);
    check("start_en", cpu_enable, 1);
    check("start_data", i_datain, 16'h0000);
    check("start_busy", busy, 1);
  endtask
  task automatic expect_word(input string tag, input logic [15:0] w);
    tick;
    check(tag, i_datain, w);
    check({tag, "_en"}, cpu_enable, 1);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_start"}, cpu_start, 0);
    check({tag, "_done"}, done, 0);
  endtask
  task automatic expect_done(input string tag, input logic [15:0] w);
    tick;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_data"}, i_datain, w);
    check({tag, "_en"}, cpu_enable, 1);
  endtask
  initial begin
    #1 check_idle("reset");
    tick;
    reset = 1'b0;
    tick;
    check_idle("idle");
    // basic program ending in an explicit HALT
    load(0, 16'h3120);
    load(1, 16'h0000);
    load(2, 16'h0000);
    load(3, 16'h0000);
    load(4, 16'h0800);
    check_idle("after_load");
    start_run(5);
    expect_word("t1_w0", 16'h3120);
    expect_word("t1_w1", 16'h0000);
    expect_word("t1_w2", 16'h0000);
    expect_word("t1_w3", 16'h0000);
    expect_word("t1_w4", 16'h0800);
    expect_done("t1", 16'h0800);
    expect_done("t1_hold", 16'h0800);
    // auto-terminate after prog_len words
    load(0, 16'h1234);
    load(1, 16'h2345);
    load(2, 16'h4567);
    start_run(3);
    expect_word("t2_w0", 16'h1234);
    expect_word("t2_w1", 16'h2345);
    expect_word("t2_w2", 16'h4567);
    expect_word("t2_auto", 16'h0800);
    expect_done("t2", 16'h0800);
    // two pause cycles while word 1 is on the bus
    start_run(3);
    expect_word("t3_w0", 16'h1234);
    expect_word("t3_w1", 16'h2345);
    pause = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      check("t3_hold", i_datain, 16'h2345);
      check("t3_en", cpu_enable, 0);
      check("t3_busy", busy, 1);
    end
    pause = 1'b0;
    expect_word("t3_w2", 16'h4567);
    expect_word("t3_auto", 16'h0800);
    expect_done("t3", 16'h0800);
    // HALT with operand bits at index 1 stops the feed early
    load(1, 16'h0805);
    load(2, 16'h2345);
    load(3, 16'h4567);
    start_run(4);
    expect_word("t4_w0", 16'h1234);
    expect_word("t4_halt", 16'h0805);
    expect_done("t4", 16'h0805);
    expect_done("t4_hold", 16'h0805);
    // writes while busy are dropped
    start_run(1);
    load_we = 1'b1;
    load_addr = 4'd0;
    load_data = 16'hFFFF;
    tick;
    check("t5_w0", i_datain, 16'h1234);
    tick;
    check("t5_auto", i_datain, 16'h0800);
    load_we = 1'b0;
    expect_done("t5", 16'h0800);
    start_run(1);
    expect_word("t5_rerun_w0", 16'h1234);
    expect_word("t5_rerun_auto", 16'h0800);
    expect_done("t5_rerun", 16'h0800);
    // empty program issues HALT straight after START
    start_run(0);
    expect_word("t6_halt", 16'h0800);
    expect_done("t6", 16'h0800);
    // oversize prog_len saturates; run during feed is ignored
    for (int i = 0; i < 16; i++) load(4'(i), 16'h1000 + 16'(i));
    start_run(5'd31);
    for (int k = 0; k < 16; k++) begin
      run = (k == 3);
      expect_word("t7_w", 16'h1000 + 16'(k));
      run = 1'b0;
    end
    expect_word("t7_auto", 16'h0800);
    expect_done("t7", 16'h0800);
    // asynchronous reset mid-feed, then replay from index 0
    load(1, 16'h0805);
    start_run(4);
    expect_word("t8_w0", 16'h1000);
    #2 reset = 1'b1;
    #1 check_idle("t8_async");
    tick;
    reset = 1'b0;
    tick;
    check_idle("t8_idle");
    start_run(4);
    expect_word("t8_w0_again", 16'h1000);
    expect_word("t8_halt", 16'h0805);
    expect_done("t8", 16'h0805);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
